// File: rtl/fifo_uart_pkg.sv
// ---------------------------------------------------------------------------
// fifo_uart_pkg
// Shared definitions for the FIFO-draining UART transmitter.
//   tx_state_t  : transmitter state encoding (IDLE, FETCH, START, DATA, STOP)
//   FRAME_BITS  : bits per frame on the line for the default configuration
//   idxWidth()  : width of an index that counts 0..n-1, never narrower than 1
// No ports; imported by fifo_uart_tx and baud_counter.
// ---------------------------------------------------------------------------
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_STOP_BITS    = 1;

    // Start bit + data bits + stop bits, counted in bit periods.
    localparam int FRAME_BITS = 1 + DEF_DATA_WIDTH + DEF_STOP_BITS;

    // A one-value counter still needs a 1-bit register.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/baud_counter.sv
// ---------------------------------------------------------------------------
// baud_counter
// Free-running bit-period counter with two terminal counts: BIT_COUNT for a
// single serial bit and LONG_COUNT for the (possibly doubled) stop period.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   clear     in   synchronous clear; holds the count at zero
//   long_sel  in   selects LONG_COUNT as the terminal count
//   tick      out  high on the last cycle of the selected period
// ---------------------------------------------------------------------------
module baud_counter
    import fifo_uart_pkg::*;
#(
    parameter int BIT_COUNT  = 16,
    parameter int LONG_COUNT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic long_sel,
    output logic tick
);

    // Sized for the longer period so the stop phase cannot overflow.
    localparam int CW = idxWidth(LONG_COUNT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_COUNT - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_COUNT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The count wraps to zero on tick so the next bit period starts cleanly,
    // which also lets the terminal count change at a bit boundary.
    always_comb begin
        tick    = (count_q == (long_sel ? LONG_LAST : BIT_LAST));
        count_d = count_q + 1'b1;
        if (clear || tick) begin
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Pops words from an upstream FIFO and sends each as an asynchronous frame:
// one start bit (low), DATA_WIDTH data bits LSB first, STOP_BITS stop bits.
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   enable        in   allows new frames to start (looked at only in IDLE)
//   fifo_rd_val   in   upstream FIFO is non-empty
//   fifo_rd_data  in   FIFO read data, valid the cycle after a pop
//   fifo_rd_en    out  combinational single-cycle pop request
//   tx            out  serial line, idles high
//   busy          out  high whenever a frame is being fetched or sent
//   tx_done       out  one-cycle pulse in the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = DEF_STOP_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_rd_val,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int IDX_W = idxWidth(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic [IDX_W-1:0]      bitIdx_q, bitIdx_d;
    logic                  txDone_q, txDone_d;

    logic baudClear;
    logic baudLong;
    logic baudTick;
    logic popReq;

    baud_counter #(
        .BIT_COUNT  (CLKS_PER_BIT),
        .LONG_COUNT (STOP_BITS * CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (baudClear),
        .long_sel (baudLong),
        .tick     (baudTick)
    );

    // Next-state and output decode. The pop request is only ever raised in
    // IDLE, so at most one word leaves the FIFO per frame, and it is gated by
    // reset so nothing is popped while the block is held in reset.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        bitIdx_d   = bitIdx_q;
        txDone_d   = 1'b0;
        baudClear  = 1'b0;
        baudLong   = 1'b0;
        popReq     = 1'b0;
        tx         = 1'b1;
        busy       = 1'b1;

        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                baudClear = 1'b1;
                popReq    = reset & enable & fifo_rd_val;
                if (popReq) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // FIFO read data is registered, so it is valid here.
                baudClear  = 1'b1;
                shiftReg_d = fifo_rd_data;
                bitIdx_d   = '0;
                state_d    = START;
            end
            START: begin
                tx = 1'b0;
                if (baudTick) begin
                    bitIdx_d = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                tx = shiftReg_q[0];
                if (baudTick) begin
                    shiftReg_d = shiftReg_q >> 1;
                    if (bitIdx_q == LAST_IDX) begin
                        bitIdx_d = '0;
                        state_d  = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                baudLong = 1'b1;
                if (baudTick) begin
                    txDone_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fifo_rd_en = popReq;
    end

    // State, data and done-pulse registers; reset drops any in-flight word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitIdx_q   <= '0;
            txDone_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            bitIdx_q   <= bitIdx_d;
            txDone_q   <= txDone_d;
        end
    end

    assign tx_done = txDone_q;

endmodule
